// File: rtl/ibox_sequencer.sv
// ibox_sequencer: shares one combinational integer execute unit between two
// requesters. Round-robin grant, operands held for the op latency, result
// and overflow trap returned on a valid/ready port with source id and tag.
module ibox_sequencer #(
  parameter int TAG_W   = 4,
  parameter int MUL_LAT = 4,
  parameter int ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [31:0]       req0_ctrl,
  input  logic [63:0]       req0_a,
  input  logic [63:0]       req0_b,
  input  logic [TAG_W-1:0]  req0_tag,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [31:0]       req1_ctrl,
  input  logic [63:0]       req1_a,
  input  logic [63:0]       req1_b,
  input  logic [TAG_W-1:0]  req1_tag,
  output logic [63:0]       ibox_a,
  output logic [63:0]       ibox_b,
  output logic [31:0]       ibox_control,
  input  logic [63:0]       ibox_result,
  input  logic              ibox_flag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [63:0]       out_result,
  output logic              out_trap,
  output logic              out_src,
  output logic [TAG_W-1:0]  out_tag,
  input  logic              flush,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter is loaded with LAT-1; latencies are limited to 1..15.
  localparam logic [3:0] MUL_LOAD = 4'(MUL_LAT - 1);
  localparam logic [3:0] ALU_LOAD = 4'(ALU_LAT - 1);

  state_t             state;
  state_t             state_nxt;
  logic               ptr;
  logic [3:0]         cnt;

  logic               any_valid;
  logic               gnt_id;
  logic [31:0]        gnt_ctrl;
  logic [63:0]        gnt_a;
  logic [63:0]        gnt_b;
  logic [TAG_W-1:0]   gnt_tag;
  logic [4:0]         gnt_alu;
  logic               gnt_mul;
  logic [3:0]         lat_load;

  logic               accept;
  logic               capture;

  // Round-robin grant: the pointer side wins when both requesters are valid.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    if (ptr) begin
      gnt_id = req1_valid ? 1'b1 : 1'b0;
    end else begin
      gnt_id = req0_valid ? 1'b0 : 1'b1;
    end
    gnt_ctrl = gnt_id ? req1_ctrl : req0_ctrl;
    gnt_a    = gnt_id ? req1_a    : req0_a;
    gnt_b    = gnt_id ? req1_b    : req0_b;
    gnt_tag  = gnt_id ? req1_tag  : req0_tag;
    gnt_alu  = gnt_ctrl[23:19];
    gnt_mul  = (gnt_alu == 5'd7) || (gnt_alu == 5'd8) || (gnt_alu == 5'd9);
    lat_load = gnt_mul ? MUL_LOAD : ALU_LOAD;
  end

  // Next-state logic; flush takes priority over counter expiry and out_ready.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (!flush && any_valid) begin
          accept    = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        if (flush) begin
          state_nxt = IDLE;
        end else if (cnt == 4'd0) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (flush || out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Ready depends only on registered state, flush and the valid inputs.
  assign req0_ready = accept & ~gnt_id;
  assign req1_ready = accept &  gnt_id;
  assign out_valid  = (state == DONE);
  assign busy       = (state != IDLE);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Control state: grant pointer and latency counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= 1'b0;
      cnt <= 4'd0;
    end else if (accept) begin
      ptr <= ~gnt_id;
      cnt <= lat_load;
    end else if ((state == EXEC) && !flush && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Operand, control word and tag capture at accept; held until next accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ibox_a       <= '0;
      ibox_b       <= '0;
      ibox_control <= '0;
      out_src      <= 1'b0;
      out_tag      <= '0;
    end else if (accept) begin
      ibox_a       <= gnt_a;
      ibox_b       <= gnt_b;
      ibox_control <= gnt_ctrl;
      out_src      <= gnt_id;
      out_tag      <= gnt_tag;
    end
  end

  // Result and trap capture on the last execute cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_result <= '0;
      out_trap   <= 1'b0;
    end else if (capture) begin
      out_result <= ibox_result;
      out_trap   <= ibox_flag;
    end
  end

endmodule

// File: tb/tb_ibox_sequencer.sv
// Directed testbench for ibox_sequencer with a small execute-unit model.
module tb_ibox_sequencer;

  localparam int TAG_W = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              req0_valid, req0_ready;
  logic [31:0]       req0_ctrl;
  logic [63:0]       req0_a, req0_b;
  logic [TAG_W-1:0]  req0_tag;
  logic              req1_valid, req1_ready;
  logic [31:0]       req1_ctrl;
  logic [63:0]       req1_a, req1_b;
  logic [TAG_W-1:0]  req1_tag;
  logic [63:0]       ibox_a, ibox_b;
  logic [31:0]       ibox_control;
  logic [63:0]       ibox_result;
  logic              ibox_flag;
  logic              out_valid, out_ready;
  logic [63:0]       out_result;
  logic              out_trap, out_src;
  logic [TAG_W-1:0]  out_tag;
  logic              flush, busy;

  int checks = 0;
  int errors = 0;

  ibox_sequencer #(.TAG_W(TAG_W), .MUL_LAT(4), .ALU_LAT(1)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctrl(req0_ctrl),
    .req0_a(req0_a), .req0_b(req0_b), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctrl(req1_ctrl),
    .req1_a(req1_a), .req1_b(req1_b), .req1_tag(req1_tag),
    .ibox_a(ibox_a), .ibox_b(ibox_b), .ibox_control(ibox_control),
    .ibox_result(ibox_result), .ibox_flag(ibox_flag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_trap(out_trap), .out_src(out_src), .out_tag(out_tag),
    .flush(flush), .busy(busy)
  );

  always #5 clk = ~clk;

  // Execute unit model: alu 1 = add with gated overflow, 7..9 = multiply.
  logic [4:0]  m_alu;
  logic [63:0] m_sum;
  always_comb begin
    m_alu       = ibox_control[23:19];
    m_sum       = ibox_a + ibox_b;
    ibox_result = ibox_a ^ ibox_b;
    ibox_flag   = 1'b0;
    if (m_alu == 5'd1) begin
      ibox_result = m_sum;
      ibox_flag   = ibox_control[0] & (ibox_a[63] == ibox_b[63]) & (m_sum[63] != ibox_a[63]);
    end else if (m_alu >= 5'd7 && m_alu <= 5'd9) begin
      ibox_result = ibox_a * ibox_b;
    end
  end

  function automatic logic [31:0] mkctrl(input logic [4:0] alu, input logic v);
    return 32'hA400_0A80 | {8'd0, alu, 19'd0} | {31'd0, v};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic idle_inputs();
    req0_valid = 0; req0_ctrl = 0; req0_a = 0; req0_b = 0; req0_tag = 0;
    req1_valid = 0; req1_ctrl = 0; req1_a = 0; req1_b = 0; req1_tag = 0;
    out_ready = 1; flush = 0;
  endtask

  // Advance negedge by negedge until out_valid is high, bounded.
  task automatic wait_out(output bit ok);
    int n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    ok = (out_valid === 1'b1);
  endtask

  task automatic do_reset();
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    #1;
    checks++;
    if ({out_valid, busy, req0_ready, req1_ready} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl: got %b want 0000", {out_valid, busy, req0_ready, req1_ready});
    end
    checks++;
    if ({ibox_a, ibox_b, ibox_control, out_result, out_trap, out_src, out_tag} !== '0) begin
      errors++; $display("FAIL reset_data: ibox_a=%h ibox_control=%h out_result=%h want 0", ibox_a, ibox_control, out_result);
    end
    do_reset();
  endtask

  task automatic test_single_add();
    @(negedge clk);
    req0_valid = 1; req0_ctrl = mkctrl(5'd1, 1'b0); req0_a = 64'd5; req0_b = 64'd7; req0_tag = 4'd3;
    out_ready = 1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++; $display("FAIL add_ready: got %b want 10", {req0_ready, req1_ready});
    end
    @(posedge clk);
    @(negedge clk);
    req0_valid = 0;
    checks++;
    if ({busy, out_valid} !== 2'b10 || ibox_a !== 64'd5 || ibox_b !== 64'd7 || ibox_control !== mkctrl(5'd1, 1'b0)) begin
      errors++; $display("FAIL add_exec: busy=%b out_valid=%b ibox_a=%h ibox_control=%h want busy=1 valid=0 a=5", busy, out_valid, ibox_a, ibox_control);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_result !== 64'd12 || out_src !== 1'b0 || out_tag !== 4'd3 || out_trap !== 1'b0) begin
      errors++; $display("FAIL add_result: valid=%b result=%h src=%b tag=%h trap=%b want 1 12 0 3 0", out_valid, out_result, out_src, out_tag, out_trap);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL add_idle: busy=%b want 0", busy);
    end
  endtask

  task automatic test_multiply();
    @(negedge clk);
    req1_valid = 1; req1_ctrl = mkctrl(5'd7, 1'b0); req1_a = 64'd3; req1_b = 64'hFFFF_FFFF_FFFF_FFFC; req1_tag = 4'd9;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      errors++; $display("FAIL mul_ready: got %b want 01", {req0_ready, req1_ready});
    end
    @(posedge clk);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      req1_valid = 0;
      checks++;
      if (out_valid !== 1'b0 || ibox_a !== 64'd3 || ibox_b !== 64'hFFFF_FFFF_FFFF_FFFC || ibox_control !== mkctrl(5'd7, 1'b0)) begin
        errors++; $display("FAIL mul_hold_%0d: valid=%b ibox_a=%h ibox_b=%h want valid=0 a=3 b=-4", k, out_valid, ibox_a, ibox_b);
      end
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_result !== 64'hFFFF_FFFF_FFFF_FFF4 || out_src !== 1'b1 || out_tag !== 4'd9) begin
      errors++; $display("FAIL mul_result: valid=%b result=%h src=%b tag=%h want 1 fffffffffffffff4 1 9", out_valid, out_result, out_src, out_tag);
    end
    @(negedge clk);
  endtask

  task automatic test_contention();
    bit ok;
    logic exp_src;
    do_reset();
    out_ready = 1;
    req0_valid = 1; req0_ctrl = mkctrl(5'd1, 1'b0); req0_a = 64'd10; req0_b = 64'd1; req0_tag = 4'hA;
    req1_valid = 1; req1_ctrl = mkctrl(5'd1, 1'b0); req1_a = 64'd20; req1_b = 64'd2; req1_tag = 4'h5;
    for (int i = 0; i < 4; i++) begin
      exp_src = (i % 2 == 1);
      wait_out(ok);
      checks++;
      if (!ok) begin
        errors++; $display("FAIL contention_timeout_%0d: out_valid=%b want 1", i, out_valid);
      end else if (out_src !== exp_src || out_tag !== (exp_src ? 4'h5 : 4'hA) || out_result !== (exp_src ? 64'd22 : 64'd11)) begin
        errors++; $display("FAIL contention_%0d: src=%b tag=%h result=%0d want src=%b", i, out_src, out_tag, out_result, exp_src);
      end
      @(negedge clk);
    end
    req0_valid = 0; req1_valid = 0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_backpressure();
    bit ok;
    bit bad = 0;
    logic [63:0] held;
    out_ready = 0;
    @(negedge clk);
    req0_valid = 1; req0_ctrl = mkctrl(5'd1, 1'b0); req0_a = 64'd100; req0_b = 64'd23; req0_tag = 4'd6;
    @(posedge clk);
    @(negedge clk);
    req0_valid = 0;
    wait_out(ok);
    held = out_result;
    checks++;
    if (!ok || held !== 64'd123) begin
      errors++; $display("FAIL bp_first: valid=%b result=%0d want 1 123", out_valid, held);
    end
    req0_valid = 1; req1_valid = 1;
    req1_ctrl = mkctrl(5'd1, 1'b0); req1_a = 64'd1; req1_b = 64'd2; req1_tag = 4'd7;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (out_valid !== 1'b1 || out_result !== 64'd123 || out_tag !== 4'd6 || req0_ready !== 1'b0 || req1_ready !== 1'b0) bad = 1;
      @(negedge clk);
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL bp_hold: outputs changed or ready asserted under backpressure (valid=%b result=%0d)", out_valid, out_result);
    end
    out_ready = 1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      errors++; $display("FAIL bp_release_ready: got %b want 00", {req0_ready, req1_ready});
    end
    @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || {req0_ready, req1_ready} !== 2'b01) begin
      errors++; $display("FAIL bp_next_grant: busy=%b ready=%b want busy=0 ready=01", busy, {req0_ready, req1_ready});
    end
    @(negedge clk);
    req0_valid = 0; req1_valid = 0;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL bp_accept: busy=%b want 1", busy);
    end
    wait_out(ok);
    checks++;
    if (!ok || out_src !== 1'b1 || out_tag !== 4'd7 || out_result !== 64'd3) begin
      errors++; $display("FAIL bp_second: src=%b tag=%h result=%0d want 1 7 3", out_src, out_tag, out_result);
    end
    @(negedge clk);
  endtask

  task automatic test_overflow();
    bit ok;
    @(negedge clk);
    req0_valid = 1; req0_ctrl = mkctrl(5'd1, 1'b1); req0_a = 64'h7FFF_FFFF_FFFF_FFFF; req0_b = 64'd1; req0_tag = 4'd2;
    @(posedge clk);
    @(negedge clk);
    req0_valid = 0;
    wait_out(ok);
    checks++;
    if (!ok || out_trap !== 1'b1 || out_result !== 64'h8000_0000_0000_0000) begin
      errors++; $display("FAIL overflow: trap=%b result=%h want 1 8000000000000000", out_trap, out_result);
    end
    @(negedge clk);
  endtask

  task automatic test_flush();
    bit ok;
    bit seen = 0;
    @(negedge clk);
    req1_valid = 1; req1_ctrl = mkctrl(5'd8, 1'b0); req1_a = 64'd2; req1_b = 64'd3; req1_tag = 4'd4;
    @(posedge clk);
    @(negedge clk);
    req1_valid = 0;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL flush_exec: busy=%b want 1", busy);
    end
    @(negedge clk);
    flush = 1;
    @(negedge clk);
    flush = 0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_idle: busy=%b valid=%b want 0 0", busy, out_valid);
    end
    repeat (8) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++; $display("FAIL flush_no_result: out_valid=1 seen want 0");
    end
    req0_valid = 1; req0_ctrl = mkctrl(5'd1, 1'b0); req0_a = 64'd40; req0_b = 64'd2; req0_tag = 4'd1;
    flush = 1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      errors++; $display("FAIL flush_idle_ready: got %b want 00", {req0_ready, req1_ready});
    end
    @(negedge clk);
    flush = 0;
    #1;
    checks++;
    if (busy !== 1'b0 || req0_ready !== 1'b1) begin
      errors++; $display("FAIL flush_idle_accept: busy=%b req0_ready=%b want 0 1", busy, req0_ready);
    end
    @(negedge clk);
    req0_valid = 0;
    wait_out(ok);
    checks++;
    if (!ok || out_result !== 64'd42 || out_src !== 1'b0) begin
      errors++; $display("FAIL flush_after: result=%0d src=%b want 42 0", out_result, out_src);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_done();
    bit ok;
    out_ready = 0;
    @(negedge clk);
    req1_valid = 1; req1_ctrl = mkctrl(5'd1, 1'b0); req1_a = 64'd8; req1_b = 64'd9; req1_tag = 4'd8;
    @(posedge clk);
    @(negedge clk);
    req1_valid = 0;
    wait_out(ok);
    checks++;
    if (!ok || out_result !== 64'd17) begin
      errors++; $display("FAIL rst_done_pre: valid=%b result=%0d want 1 17", out_valid, out_result);
    end
    #2;
    reset = 1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_result !== 64'd0 || ibox_a !== 64'd0 || out_tag !== 4'd0) begin
      errors++; $display("FAIL rst_done: valid=%b busy=%b result=%h ibox_a=%h want all 0", out_valid, busy, out_result, ibox_a);
    end
    @(negedge clk);
    reset = 0;
    out_ready = 1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_multiply();
    test_contention();
    test_backpressure();
    test_overflow();
    test_flush();
    test_reset_mid_done();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ibox_sequencer.md
Name: ibox_sequencer

Overview:
- Shares one combinational integer execute unit between two requesters (req0, req1).
- Round-robin arbitration picks one op at a time; operands and the 32-bit control word are held stable for the op's latency.
- The result and overflow trap are captured and returned on a valid/ready output with the requester's id and tag.
- Sits between the integer issue stage and the execute unit; the execute unit's a/b/control/result/flag pins connect directly to this block.

Parameters:
- TAG_W, 4, width of the per-op tag returned with the result.
- MUL_LAT, 4, execute cycles for multiply ops (ctrl alu field 7, 8 or 9); legal range 1..15.
- ALU_LAT, 1, execute cycles for all other ops; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has an op.
- req0_ready  out  1  requester 0 op accepted this cycle.
- req0_ctrl  in  32  execute control word.
- req0_a, req0_b  in  64 each  operands.
- req0_tag  in  TAG_W  opaque tag.
- req1_valid / req1_ready / req1_ctrl / req1_a / req1_b / req1_tag  same widths and meanings, requester 1.
- ibox_a, ibox_b  out  64 each  registered operands to the execute unit.
- ibox_control  out  32  registered control word.
- ibox_result  in  64  execute unit result (combinational from ibox_*).
- ibox_flag  in  1  execute unit overflow flag (already gated by the control v bit).
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_result  out  64  captured result.
- out_trap  out  1  captured ibox_flag.
- out_src  out  1  requester id (0/1).
- out_tag  out  TAG_W  tag of the op.
- flush  in  1  synchronous abort of the in-flight op.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (asynchronous): state=IDLE, priority pointer=0, all outputs 0 (ibox_a, ibox_b, ibox_control, out_* included), cycle counter=0.
- Control word field layout, msb to lsb: n_shift[31:26], shifter[25:24], alu[23:19], cmp[18:16], mei[15:11], xor[10:8], mux0[7], mux1[6], mux2[5:3], mux3[2:1], v[0]. Only alu[23:19] is decoded here; all other fields pass through untouched.
- IDLE:
  - reqN_ready is combinational and asserted only in IDLE, only for the granted requester, and only when flush=0.
  - Grant is reqP_valid ? P : reqQ_valid ? Q, where P is the pointer and Q=~P.
  - On accept: latch ctrl/a/b into ibox_*, latch tag and src, load counter=LAT-1 (LAT=MUL_LAT if alu in {7,8,9}, else ALU_LAT), pointer<=~granted, go to EXEC.
  - With no valid request: stay in IDLE, pointer unchanged.
- EXEC:
  - ibox_* held constant.
  - counter!=0: decrement.
  - counter==0: out_result<=ibox_result, out_trap<=ibox_flag, go to DONE.
  - Latency: accept at edge T; EXEC covers cycles T+1..T+LAT; out_valid is high from cycle T+LAT+1.
- DONE:
  - out_valid=1; out_* stable while out_ready=0.
  - out_valid & out_ready: go to IDLE. No new accept in that same cycle.
  - Minimum issue interval is LAT+2 cycles.
- flush:
  - EXEC or DONE: go to IDLE next edge; out_valid drops; no result delivered; pointer keeps its post-grant value.
  - IDLE: suppresses all ready signals that cycle.
  - flush has priority over out_ready and counter expiry.
- Simultaneous valid on both requesters: the pointer side wins. Alternation is strict under continuous contention.
- A request that is not accepted must be held by the requester; no state is kept for it.
- ibox_* keep their last values in IDLE and DONE. No output glitches on ready (registered state only, plus valid inputs).
- Reset asserted mid-op: op is lost, all outputs return to reset values immediately.

Test Plan:
- Single add:
  - Stimulus: req0 ctrl alu=1, a=5, b=7, tag=3, ALU_LAT=1, out_ready=1; model execute unit.
  - Response: accept at T; out_valid at T+2 with out_result=12, out_src=0, out_tag=3, out_trap=0.
- Multiply latency:
  - Stimulus: req1 alu=7, a=3, b=-4, MUL_LAT=4.
  - Response: ibox_* stable cycles T+1..T+4; out_valid at T+5 with result=0xFFFF_FFFF_FFFF_FFF4.
- Contention:
  - Stimulus: both valid continuously for 4 ops after reset.
  - Response: grant order 0,1,0,1; each tag returned with matching out_src.
- Backpressure:
  - Stimulus: out_ready=0 for 6 cycles after out_valid.
  - Response: out_* constant, both ready signals stay 0; out_ready=1 -> IDLE next cycle, next grant the cycle after.
- Overflow:
  - Stimulus: alu=1, v=1, a=0x7FFF_FFFF_FFFF_FFFF, b=1, execute unit flag=1.
  - Response: out_trap=1, out_result=0x8000_0000_0000_0000.
- Flush/reset:
  - Stimulus: flush in EXEC cycle 2 of a multiply.
  - Response: no out_valid, IDLE next cycle.
  - Stimulus: reset asserted mid-DONE.
  - Response: out_valid=0 and busy=0 immediately, before the next clock edge.
